// File: rtl/pc_stat_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_stat_display_pkg
//  Brief    : Shared encodings for the Pc statistics display: counter select
//             codes, converter FSM states and seven-segment glyphs.
//  Revision : 1.0  initial release
// ============================================================================
package pc_stat_display_pkg;

    localparam logic [1:0] SEL_TOTAL  = 2'd0;
    localparam logic [1:0] SEL_UNCOND = 2'd1;
    localparam logic [1:0] SEL_COND   = 2'd2;
    localparam logic [1:0] SEL_CONDOK = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Active-low g..a glyphs
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_code(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_stat_display_seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Brief    : Nibble plus blank flag to active-low seven-segment code.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import pc_stat_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] code
);

    always_comb begin
        code = SEG_BLANK;
        if (!blank) begin
            code = seg7_code(nibble);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_stat_display.sv
`default_nettype none
// ============================================================================
//  Module   : pc_stat_display
//  Brief    : Snapshots one Pc statistics counter, converts it to BCD (or
//             passes hex) and scans it onto an 8-digit seven-segment display.
//  Revision : 1.0  initial release
// ============================================================================
module pc_stat_display
    import pc_stat_display_pkg::*;
#(
    parameter int COUNT_WIDTH = 25,
    parameter int SCAN_DIV    = 100000,
    parameter int SAMPLE_DIV  = 10000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             select,
    input  logic                   hexMode,
    input  logic [COUNT_WIDTH-1:0] totalCycle,
    input  logic [COUNT_WIDTH-1:0] unconditionalJump,
    input  logic [COUNT_WIDTH-1:0] conditionalJump,
    input  logic [COUNT_WIDTH-1:0] conditionalSuccessfulJump,
    output logic [7:0]             anode,
    output logic [7:0]             segment,
    output logic                   busy
);

    localparam int C_SAMPLE_W = $clog2(SAMPLE_DIV + 1);
    localparam int C_SCAN_W   = $clog2(SCAN_DIV + 1);
    localparam int C_SHIFT_W  = $clog2(COUNT_WIDTH + 1);

    logic [C_SAMPLE_W-1:0]  r_sample_cnt;
    logic [C_SCAN_W-1:0]    r_scan_cnt;
    logic [2:0]             r_digit;
    logic [1:0]             r_state;
    logic [COUNT_WIDTH-1:0] r_snapshot;
    logic                   r_hex;
    logic [1:0]             r_sel;
    logic [31:0]            r_bcd;
    logic [C_SHIFT_W-1:0]   r_shift_cnt;
    logic [31:0]            r_display;
    logic [7:0]             r_blank;
    logic [1:0]             r_dp_sel;
    logic [7:0]             r_anode;
    logic [7:0]             r_segment;

    logic                        w_tick;
    logic [COUNT_WIDTH-1:0]      w_sel_count;
    logic [31:0]                 w_bcd_adj;
    logic [31+COUNT_WIDTH:0]     w_shifted;
    logic [31:0]                 w_result;
    logic [7:0]                  w_blank;
    logic [3:0]                  w_nibble;
    logic                        w_digit_blank;
    logic                        w_dp_on;
    logic [6:0]                  w_seg7;

    assign w_tick = (r_sample_cnt == '0);
    assign busy   = (r_state != ST_IDLE);

    always_comb begin
        w_sel_count = totalCycle;
        case (select)
            SEL_UNCOND: w_sel_count = unconditionalJump;
            SEL_COND:   w_sel_count = conditionalJump;
            SEL_CONDOK: w_sel_count = conditionalSuccessfulJump;
            default:    w_sel_count = totalCycle;
        endcase
    end

    // Double-dabble: correct every nibble >= 5 before the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 8; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted = {w_bcd_adj, r_snapshot} << 1;
    assign w_result  = r_hex ? 32'(r_snapshot) : r_bcd;

    // Leading zeros blank from the top down; digit 0 always shows
    always_comb begin
        logic seen_nonzero;
        seen_nonzero = 1'b0;
        w_blank      = 8'h00;
        for (int i = 7; i >= 1; i--) begin
            if (w_result[4*i +: 4] != 4'h0) begin
                seen_nonzero = 1'b1;
            end
            w_blank[i] = ~seen_nonzero;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sample_cnt <= '0;
        end else if (r_sample_cnt == C_SAMPLE_W'(SAMPLE_DIV - 1)) begin
            r_sample_cnt <= '0;
        end else begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_snapshot  <= '0;
            r_hex       <= 1'b0;
            r_sel       <= SEL_TOTAL;
            r_bcd       <= '0;
            r_shift_cnt <= '0;
            r_display   <= '0;
            r_blank     <= 8'hFF;
            r_dp_sel    <= SEL_TOTAL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_snapshot <= w_sel_count;
                        r_hex      <= hexMode;
                        r_sel      <= select;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_bcd       <= '0;
                    r_shift_cnt <= '0;
                    r_state     <= r_hex ? ST_DONE : ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_bcd       <= w_shifted[31+COUNT_WIDTH:COUNT_WIDTH];
                    r_snapshot  <= w_shifted[COUNT_WIDTH-1:0];
                    r_shift_cnt <= r_shift_cnt + 1'b1;
                    if (r_shift_cnt == C_SHIFT_W'(COUNT_WIDTH - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_display <= w_result;
                    r_blank   <= w_blank;
                    r_dp_sel  <= r_sel;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_digit    <= 3'd0;
        end else if (r_scan_cnt == C_SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign w_nibble      = r_display[{r_digit, 2'b00} +: 4];
    assign w_digit_blank = r_blank[r_digit];
    // A blanked digit stays fully dark, decimal point included
    assign w_dp_on       = !w_digit_blank && (r_digit == {1'b0, r_dp_sel});

    seg7_decode u_seg7_decode (
        .nibble (w_nibble),
        .blank  (w_digit_blank),
        .code   (w_seg7)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_anode   <= 8'hFF;
            r_segment <= 8'hFF;
        end else begin
            r_anode   <= ~(8'b1 << r_digit);
            r_segment <= {~w_dp_on, w_seg7};
        end
    end

    assign anode   = r_anode;
    assign segment = r_segment;

endmodule
`default_nettype wire

// File: tb/tb_pc_stat_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_stat_display
//  Brief    : Directed self-checking bench for pc_stat_display.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_stat_display;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  select;
    logic        hexMode;
    logic [24:0] totalCycle;
    logic [24:0] unconditionalJump;
    logic [24:0] conditionalJump;
    logic [24:0] conditionalSuccessfulJump;
    logic [7:0]  anode;
    logic [7:0]  segment;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pc_stat_display #(
        .COUNT_WIDTH (25),
        .SCAN_DIV    (2),
        .SAMPLE_DIV  (64)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .select                    (select),
        .hexMode                   (hexMode),
        .totalCycle                (totalCycle),
        .unconditionalJump         (unconditionalJump),
        .conditionalJump           (conditionalJump),
        .conditionalSuccessfulJump (conditionalSuccessfulJump),
        .anode                     (anode),
        .segment                   (segment),
        .busy                      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input logic level, input string tag);
        int n;
        n = 0;
        while (busy !== level && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk(tag, {31'd0, busy}, {31'd0, level});
    endtask

    task automatic count_high(input string tag, input int exp);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
        end
        chk(tag, n, exp);
    endtask

    task automatic measure_busy(input string tag, input int exp);
        wait_busy(1'b0, {tag, "_idle"});
        wait_busy(1'b1, {tag, "_start"});
        count_high(tag, exp);
    endtask

    task automatic check_digit(input int d, input logic [7:0] exp, input string tag);
        logic [7:0] want_an;
        int n;
        want_an = ~(8'b1 << d);
        @(negedge clock);
        n = 0;
        while (anode !== want_an && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_an"}, {24'd0, anode}, {24'd0, want_an});
        chk(tag, {24'd0, segment}, {24'd0, exp});
    endtask

    initial begin
        reset                     = 1'b1;
        select                    = 2'd0;
        hexMode                   = 1'b0;
        totalCycle                = 25'd12345678;
        unconditionalJump         = 25'd0;
        conditionalJump           = 25'd0;
        conditionalSuccessfulJump = 25'd0;
        repeat (3) @(negedge clock);
        chk("rst_anode",   {24'd0, anode},   32'hFF);
        chk("rst_segment", {24'd0, segment}, 32'hFF);
        chk("rst_busy",    {31'd0, busy},    32'd0);

        // 1: decimal 12345678 on total, dp on digit 0
        reset = 1'b0;
        measure_busy("t1_busy", 27);
        check_digit(0, 8'h00, "t1_d0");
        check_digit(1, 8'hF8, "t1_d1");
        check_digit(7, 8'hF9, "t1_d7");

        // 2: zero value shows a single undotted 0
        select            = 2'd1;
        unconditionalJump = 25'd0;
        measure_busy("t2_busy", 27);
        check_digit(0, 8'hC0, "t2_d0");
        check_digit(1, 8'hFF, "t2_d1");
        check_digit(7, 8'hFF, "t2_d7");

        // 3: hex mode
        select          = 2'd2;
        hexMode         = 1'b1;
        conditionalJump = 25'h1ABCDEF;
        measure_busy("t3_busy", 2);
        check_digit(0, 8'h8E, "t3_d0");
        check_digit(1, 8'h86, "t3_d1");
        check_digit(2, 8'h21, "t3_d2");
        check_digit(3, 8'hC6, "t3_d3");
        check_digit(5, 8'h88, "t3_d5");
        check_digit(6, 8'hF9, "t3_d6");
        check_digit(7, 8'hFF, "t3_d7");

        // 4: full-scale decimal 33554431
        select                    = 2'd3;
        hexMode                   = 1'b0;
        conditionalSuccessfulJump = 25'h1FFFFFF;
        measure_busy("t4_busy", 27);
        check_digit(0, 8'hF9, "t4_d0");
        check_digit(3, 8'h19, "t4_d3");
        check_digit(6, 8'hB0, "t4_d6");
        check_digit(7, 8'hB0, "t4_d7");

        // 5: select change during a conversion waits for the next tick
        select            = 2'd0;
        totalCycle        = 25'd100;
        unconditionalJump = 25'd7;
        wait_busy(1'b0, "t5_idle");
        wait_busy(1'b1, "t5_start");
        select = 2'd1;
        wait_busy(1'b0, "t5_done");
        check_digit(0, 8'h40, "t5_d0");
        check_digit(1, 8'hC0, "t5_d1");
        check_digit(2, 8'hF9, "t5_d2");
        check_digit(3, 8'hFF, "t5_d3");
        measure_busy("t5_next_busy", 27);
        check_digit(0, 8'hF8, "t5_next_d0");
        check_digit(1, 8'hFF, "t5_next_d1");

        // 6: reset in SHIFT cycle 10 aborts, then a fresh conversion starts
        select     = 2'd0;
        totalCycle = 25'd12345678;
        wait_busy(1'b0, "t6_idle");
        wait_busy(1'b1, "t6_start");
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_rst_busy",    {31'd0, busy},    32'd0);
        chk("t6_rst_anode",   {24'd0, anode},   32'hFF);
        chk("t6_rst_segment", {24'd0, segment}, 32'hFF);
        reset = 1'b0;
        @(negedge clock);
        chk("t6_restart", {31'd0, busy}, 32'd1);
        count_high("t6_busy", 27);
        check_digit(0, 8'h00, "t6_d0");
        check_digit(7, 8'hF9, "t6_d7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
